// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store memory sequencer
// and its load-alignment helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    EXC_LD_MIS   = 2'd0,
    EXC_ST_MIS   = 2'd1,
    EXC_LD_FAULT = 2'd2,
    EXC_ST_FAULT = 2'd3
  } exc_cause_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [2:0] off
  );
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  function automatic logic f3_invalid(
    input logic       store,
    input logic [2:0] f3
  );
    f3_invalid = store ? f3[2] : (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the read word down to the addressed byte
// lane and sign- or zero-extends according to funct3.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int N = 64
) (
  input  logic [N-1:0]           i_rdata,
  input  logic [$clog2(N/8)-1:0] i_off,
  input  logic [2:0]             i_funct3,
  output logic [N-1:0]           o_data
);

  logic [N-1:0] w_sh;

  assign w_sh = i_rdata >> {i_off, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_funct3)
      F3_B:    o_data = N'($signed(w_sh[7:0]));
      F3_H:    o_data = N'($signed(w_sh[15:0]));
      F3_W:    o_data = N'($signed(w_sh[31:0]));
      F3_BU:   o_data = N'(w_sh[7:0]);
      F3_HU:   o_data = N'(w_sh[15:0]);
      F3_WU:   o_data = N'(w_sh[31:0]);
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequences one load/store at a time onto a
// valid/ready data-memory port, with alignment and fault checks.
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_valid,
  input  logic           req_load,
  input  logic           req_store,
  input  logic [2:0]     req_funct3,
  input  logic [N-1:0]   req_addr,
  input  logic [N-1:0]   req_storeData,
  output logic           req_ready,
  output logic           stall,
  output logic           resp_valid,
  output logic [N-1:0]   resp_loadData,
  output logic           exc_valid,
  output logic [1:0]     exc_cause,
  output logic [N-1:0]   exc_addr,
  output logic           mem_req_valid,
  input  logic           mem_req_ready,
  output logic           mem_we,
  output logic [N-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic [N/8-1:0] mem_wmask,
  input  logic           mem_rsp_valid,
  input  logic [N-1:0]   mem_rsp_rdata,
  input  logic           mem_rsp_err
);

  localparam int NB = N / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2);

  lsu_state_e    r_state;
  lsu_state_e    w_next;
  logic [N-1:0]  r_addr;
  logic [N-1:0]  r_sdata;
  logic [N-1:0]  r_rdata;
  logic [2:0]    r_f3;
  logic          r_store;
  logic          r_exc;
  logic          r_inv;
  exc_cause_e    r_cause;
  logic [CW-1:0] r_cnt;

  logic          w_op;
  logic          w_store;
  logic          w_mis;
  logic          w_inv;
  logic          w_accept;
  logic          w_busy;
  logic          w_hs;
  logic          w_rsp;
  logic          w_tmo;
  logic [OW-1:0] w_off;
  logic [NB-1:0] w_bmask;
  logic [N-1:0]  w_ld;

  // Gating with rst_n keeps req_ready/stall low while reset is held.
  assign w_op     = rst_n & req_valid & (req_load | req_store);
  assign w_store  = req_store & ~req_load;
  assign w_mis    = misaligned(req_funct3[1:0], req_addr[2:0]);
  assign w_inv    = f3_invalid(w_store, req_funct3);
  assign w_accept = (r_state == IDLE) & w_op;
  assign w_busy   = (r_state == REQ) | (r_state == WAIT);
  assign w_hs     = (r_state == REQ) & mem_req_ready;
  assign w_rsp    = (r_state == WAIT) & mem_rsp_valid;
  assign w_off    = r_addr[OW-1:0];

  // A handshake or response in the expiry cycle wins over the timeout.
  assign w_tmo = w_busy & (r_cnt >= CW'(TIMEOUT - 1)) & ~w_hs & ~w_rsp;

  always_comb begin
    case (r_f3[1:0])
      2'd0:    w_bmask = NB'(8'h01);
      2'd1:    w_bmask = NB'(8'h03);
      2'd2:    w_bmask = NB'(8'h0F);
      default: w_bmask = NB'(8'hFF);
    endcase
  end

  lsu_load_align #(.N(N)) u_align (
    .i_rdata  (r_rdata),
    .i_off    (w_off),
    .i_funct3 (r_f3),
    .o_data   (w_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_sdata <= '0;
      r_rdata <= '0;
      r_f3    <= '0;
      r_store <= 1'b0;
      r_exc   <= 1'b0;
      r_inv   <= 1'b0;
      r_cause <= EXC_LD_MIS;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_sdata <= req_storeData;
        r_f3    <= req_funct3;
        r_store <= w_store;
        r_exc   <= w_mis;
        r_inv   <= w_inv & ~w_mis;
        r_cause <= w_store ? EXC_ST_MIS : EXC_LD_MIS;
        r_rdata <= '0;
        r_cnt   <= '0;
      end
      if (w_busy) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_rsp) begin
        r_rdata <= mem_rsp_rdata;
      end
      if (w_tmo | (w_rsp & mem_rsp_err)) begin
        r_exc   <= 1'b1;
        r_cause <= r_store ? EXC_ST_FAULT : EXC_LD_FAULT;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    req_ready     = 1'b0;
    stall         = 1'b0;
    resp_valid    = 1'b0;
    resp_loadData = '0;
    exc_valid     = 1'b0;
    exc_cause     = 2'd0;
    exc_addr      = '0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wmask     = '0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_op;
        stall     = w_op;
        if (w_op) begin
          w_next = (w_mis | w_inv) ? RESP : REQ;
        end
      end
      REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_we        = r_store;
        mem_addr      = r_addr;
        if (r_store) begin
          mem_wmask = w_bmask << w_off;
          mem_wdata = r_sdata << {w_off, 3'b000};
        end
        if (mem_req_ready) begin
          w_next = WAIT;
        end else if (w_tmo) begin
          w_next = RESP;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_rsp_valid | w_tmo) begin
          w_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        exc_valid  = r_exc;
        w_next     = IDLE;
        if (r_exc) begin
          exc_cause = r_cause;
          exc_addr  = r_addr;
        end else if (!r_store && !r_inv) begin
          resp_loadData = w_ld;
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed and randomized checks of the LSU memory
// sequencer against a transaction-level reference model.
module tb_lsu_mem_ctrl;

  localparam int N   = 64;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_load = 1'b0;
  logic          req_store = 1'b0;
  logic [2:0]    req_funct3 = '0;
  logic [N-1:0]  req_addr = '0;
  logic [N-1:0]  req_storeData = '0;
  logic          req_ready;
  logic          stall;
  logic          resp_valid;
  logic [N-1:0]  resp_loadData;
  logic          exc_valid;
  logic [1:0]    exc_cause;
  logic [N-1:0]  exc_addr;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_we;
  logic [N-1:0]  mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N/8-1:0] mem_wmask;
  logic          mem_rsp_valid = 1'b0;
  logic [N-1:0]  mem_rsp_rdata = '0;
  logic          mem_rsp_err = 1'b0;

  lsu_mem_ctrl #(.N(N), .TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_load      (req_load),
    .req_store     (req_store),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_storeData (req_storeData),
    .req_ready     (req_ready),
    .stall         (stall),
    .resp_valid    (resp_valid),
    .resp_loadData (resp_loadData),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .exc_addr      (exc_addr),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .mem_rsp_err   (mem_rsp_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int          resp_cyc;
    int          nreqv;
    logic        we;
    logic [63:0] maddr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic [63:0] eaddr;
    int          stall_bad;
    int          rdy_bad;
  } obs_t;

  function automatic logic [N*3+10:0] all_outs();
    return {req_ready, stall, resp_valid, resp_loadData, exc_valid,
            exc_cause, exc_addr, mem_req_valid, mem_we, mem_addr,
            mem_wdata, mem_wmask};
  endfunction

  // Transaction model: latency from bus delays, data from RISC-V rules.
  function automatic obs_t model(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [63:0] addr, input logic [63:0] sdata,
    input logic [63:0] rdata, input int rdy, input int rsp,
    input logic err
  );
    obs_t m;
    logic is_st, inv, fault;
    int bytes, off, r, w, t, lim;
    logic [63:0] sh;
    m = '{default: 0};
    is_st = st && !ld;
    bytes = 1 << int'(f3[1:0]);
    off = int'(addr[2:0]);
    inv = is_st ? (f3 >= 3'd4) : (f3 == 3'd7);
    if ((off % bytes) != 0) begin
      m.resp_cyc = 1;
      m.exc = 1'b1;
      m.cause = is_st ? 2'd1 : 2'd0;
      m.eaddr = addr;
      return m;
    end
    if (inv) begin
      m.resp_cyc = 1;
      return m;
    end
    r = rdy + 1;
    w = rsp + 1;
    if (r > TMO) begin
      t = TMO;
      fault = 1'b1;
      m.nreqv = TMO;
    end else begin
      m.nreqv = r;
      lim = (TMO > r + 1) ? TMO : r + 1;
      if (r + w <= lim) begin
        t = r + w;
        fault = err;
      end else begin
        t = lim;
        fault = 1'b1;
      end
    end
    m.resp_cyc = t + 1;
    m.we = is_st;
    m.maddr = addr;
    if (is_st) begin
      m.wmask = 8'(((1 << bytes) - 1) << off);
      m.wdata = sdata << (8 * off);
    end
    if (fault) begin
      m.exc = 1'b1;
      m.cause = is_st ? 2'd3 : 2'd2;
      m.eaddr = addr;
    end else if (!is_st) begin
      sh = rdata >> (8 * off);
      case (f3)
        3'd0:    m.data = {{56{sh[7]}}, sh[7:0]};
        3'd1:    m.data = {{48{sh[15]}}, sh[15:0]};
        3'd2:    m.data = {{32{sh[31]}}, sh[31:0]};
        3'd4:    m.data = {56'd0, sh[7:0]};
        3'd5:    m.data = {48'd0, sh[15:0]};
        3'd6:    m.data = {32'd0, sh[31:0]};
        default: m.data = sh;
      endcase
    end
    return m;
  endfunction

  // Drives one op and acts as the bus; cycle 0 is the accept cycle.
  task automatic run_op(
    input logic ld, input logic st, input logic [2:0] f3,
    input logic [63:0] addr, input logic [63:0] sdata,
    input logic [63:0] rdata, input int rdy, input int rsp,
    input logic err, output obs_t o
  );
    int hc;
    int waitn;
    logic done;
    o = '{default: 0};
    hc = -1;
    waitn = 0;
    done = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_load = ld;
    req_store = st;
    req_funct3 = f3;
    req_addr = addr;
    req_storeData = sdata;
    mem_req_ready = 1'b0;
    #1;
    if (req_ready !== 1'b1) o.rdy_bad++;
    if (stall !== 1'b1) o.stall_bad++;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_load = 1'b0;
      req_store = 1'b0;
      req_addr = {$urandom, $urandom};
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rsp_err = 1'b0;
      mem_rsp_rdata = {$urandom, $urandom};
      #1;
      if (resp_valid === 1'b1) begin
        o.resp_cyc = c;
        o.data = resp_loadData;
        o.exc = exc_valid;
        o.cause = exc_cause;
        o.eaddr = exc_addr;
        if (stall !== 1'b0) o.stall_bad++;
        if (req_ready !== 1'b0) o.rdy_bad++;
        if (mem_req_valid !== 1'b0) o.nreqv++;
        mem_rsp_valid = 1'b1;
        mem_rsp_err = 1'b1;
        done = 1'b1;
      end else begin
        if (stall !== 1'b1) o.stall_bad++;
        if (req_ready !== 1'b0) o.rdy_bad++;
        if (mem_req_valid === 1'b1) begin
          o.nreqv++;
          o.we = mem_we;
          o.maddr = mem_addr;
          o.wdata = mem_wdata;
          o.wmask = mem_wmask;
          if (o.nreqv > rdy) begin
            mem_req_ready = 1'b1;
            hc = c;
          end else if ($urandom_range(0, 2) == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_err = 1'b1;
          end
        end else if (hc >= 0) begin
          waitn++;
          if (waitn > rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            mem_rsp_err = err;
          end
        end
      end
    end
  endtask

  task automatic quiet();
    req_valid = 1'b0;
    req_load = 1'b0;
    req_store = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_load = 1'b1;
    #12;
    vectors++;
    if (req_ready !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_hold rdy=%b stall=%b want 0", req_ready, stall);
    end
    quiet();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++;
      $display("FAIL rst_outs got %h want 0", all_outs());
    end
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    vectors++;
    if (req_ready !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL no_op rdy=%b stall=%b want 0", req_ready, stall);
    end
    quiet();
  endtask

  task automatic test_lw();
    obs_t o;
    run_op(1, 0, 3'b010, 64'h1004, 0, 64'h80000000_00000000, 0, 0, 0, o);
    vectors++;
    if (o.resp_cyc != 3 || o.exc !== 1'b0) begin
      miscompares++;
      $display("FAIL lw_lat cyc=%0d exc=%b want 3/0", o.resp_cyc, o.exc);
    end
    vectors++;
    if (o.data !== 64'hFFFFFFFF_80000000) begin
      miscompares++;
      $display("FAIL lw_data got %h want ffffffff80000000", o.data);
    end
  endtask

  task automatic test_byte_ext();
    obs_t o;
    run_op(1, 0, 3'b100, 64'h1003, 0, 64'hF1000000, 0, 0, 0, o);
    vectors++;
    if (o.data !== 64'h00000000_000000F1) begin
      miscompares++;
      $display("FAIL lbu_data got %h want f1", o.data);
    end
    run_op(1, 0, 3'b000, 64'h1003, 0, 64'hF1000000, 0, 0, 0, o);
    vectors++;
    if (o.data !== 64'hFFFFFFFF_FFFFFFF1) begin
      miscompares++;
      $display("FAIL lb_data got %h want fffffffffffffff1", o.data);
    end
  endtask

  task automatic test_sh_wait();
    obs_t o;
    run_op(0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 3, 0, 0, o);
    vectors++;
    if (o.nreqv != 4 || o.we !== 1'b1 || o.maddr !== 64'h2006) begin
      miscompares++;
      $display("FAIL sh_req n=%0d we=%b a=%h want 4/1/2006",
               o.nreqv, o.we, o.maddr);
    end
    vectors++;
    if (o.wmask !== 8'hC0 || o.wdata !== 64'hABCD0000_00000000) begin
      miscompares++;
      $display("FAIL sh_lane mask=%h data=%h want c0/abcd000000000000",
               o.wmask, o.wdata);
    end
    vectors++;
    if (o.stall_bad != 0 || o.resp_cyc != 6 || o.exc !== 1'b0) begin
      miscompares++;
      $display("FAIL sh_resp stallbad=%0d cyc=%0d exc=%b want 0/6/0",
               o.stall_bad, o.resp_cyc, o.exc);
    end
  endtask

  task automatic test_sw_misaligned();
    obs_t o;
    run_op(0, 1, 3'b010, 64'h3002, 64'h1234, 0, 0, 0, 0, o);
    vectors++;
    if (o.resp_cyc != 1 || o.nreqv != 0) begin
      miscompares++;
      $display("FAIL sw_mis_lat cyc=%0d nreq=%0d want 1/0", o.resp_cyc, o.nreqv);
    end
    vectors++;
    if (o.exc !== 1'b1 || o.cause !== 2'd1 || o.eaddr !== 64'h3002) begin
      miscompares++;
      $display("FAIL sw_mis_exc v=%b c=%0d a=%h want 1/1/3002",
               o.exc, o.cause, o.eaddr);
    end
  endtask

  task automatic test_faults();
    obs_t o;
    run_op(1, 0, 3'b011, 64'h4000, 0, 64'hDEAD, 0, 0, 1, o);
    vectors++;
    if (o.exc !== 1'b1 || o.cause !== 2'd2 || o.data !== 64'd0 ||
        o.eaddr !== 64'h4000) begin
      miscompares++;
      $display("FAIL ld_err v=%b c=%0d d=%h a=%h want 1/2/0/4000",
               o.exc, o.cause, o.data, o.eaddr);
    end
    run_op(1, 0, 3'b011, 64'h4000, 0, 64'hDEAD, 30, 0, 0, o);
    vectors++;
    if (o.nreqv != 4 || o.resp_cyc != 5 || o.exc !== 1'b1 ||
        o.cause !== 2'd2) begin
      miscompares++;
      $display("FAIL ld_tmo n=%0d cyc=%0d v=%b c=%0d want 4/5/1/2",
               o.nreqv, o.resp_cyc, o.exc, o.cause);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    @(negedge clk);
    req_valid = 1'b1;
    req_load = 1'b1;
    req_funct3 = 3'b011;
    req_addr = 64'h5000;
    @(negedge clk);
    quiet();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    vectors++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_wait stall=%b mrv=%b want 1/0", stall, mem_req_valid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++;
      $display("FAIL mid_rst got %h want 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1;
    mem_rsp_err = 1'b1;
    mem_rsp_rdata = 64'hBAD;
    @(negedge clk);
    quiet();
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || all_outs() !== '0) begin
      miscompares++;
      $display("FAIL late_rsp got %h want 0", all_outs());
    end
    run_op(1, 0, 3'b011, 64'h4000, 0, 64'h01234567_89ABCDEF, 0, 0, 0, o);
    vectors++;
    if (o.resp_cyc != 3 || o.exc !== 1'b0 ||
        o.data !== 64'h01234567_89ABCDEF) begin
      miscompares++;
      $display("FAIL after_rst cyc=%0d v=%b d=%h want 3/0/0123456789abcdef",
               o.resp_cyc, o.exc, o.data);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1;
    req_store = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 64'h3002;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_acc0 rdy=%b want 1", req_ready);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || req_ready !== 1'b0 || stall !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_resp rv=%b rdy=%b st=%b want 1/0/0",
               resp_valid, req_ready, stall);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_acc1 rv=%b rdy=%b want 0/1", resp_valid, req_ready);
    end
    @(negedge clk);
    quiet();
    #1;
    vectors++;
    if (resp_valid !== 1'b1 || exc_cause !== 2'd1) begin
      miscompares++;
      $display("FAIL b2b_resp2 rv=%b c=%0d want 1/1", resp_valid, exc_cause);
    end
  endtask

  task automatic test_random(input int n);
    obs_t e, o;
    logic ld, st, is_st;
    logic [2:0] f3;
    logic [63:0] addr, sdata, rdata;
    int rdy, rsp, bytes;
    logic err;
    for (int i = 0; i < n; i++) begin
      ld = 1'($urandom_range(0, 1));
      st = 1'($urandom_range(0, 1));
      if (!ld && !st) ld = 1'b1;
      is_st = st && !ld;
      f3 = 3'($urandom_range(0, 7));
      addr = {$urandom, $urandom};
      bytes = 1 << int'(f3[1:0]);
      if ($urandom_range(0, 3) != 0)
        addr[2:0] = addr[2:0] & 3'(~(bytes - 1));
      if ((is_st && f3[2]) || (!is_st && f3 == 3'd7))
        addr[2:0] = 3'd0;
      sdata = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      rdy = $urandom_range(0, 4);
      rsp = $urandom_range(0, 3);
      err = ($urandom_range(0, 5) == 0);
      e = model(ld, st, f3, addr, sdata, rdata, rdy, rsp, err);
      run_op(ld, st, f3, addr, sdata, rdata, rdy, rsp, err, o);
      vectors++;
      if (o.resp_cyc != e.resp_cyc || o.nreqv != e.nreqv ||
          o.data !== e.data || o.exc !== e.exc || o.cause !== e.cause ||
          o.eaddr !== e.eaddr || o.stall_bad != 0 || o.rdy_bad != 0 ||
          (e.nreqv > 0 && (o.we !== e.we || o.maddr !== e.maddr ||
           o.wmask !== e.wmask || o.wdata !== e.wdata))) begin
        miscompares++;
        $display("FAIL rand[%0d] l%b s%b f3=%0d a=%h: cyc %0d/%0d nreq %0d/%0d d %h/%h exc %b%0d/%b%0d m %h/%h w %h/%h sb%0d rb%0d",
                 i, ld, st, f3, addr, o.resp_cyc, e.resp_cyc, o.nreqv,
                 e.nreqv, o.data, e.data, o.exc, o.cause, e.exc, e.cause,
                 o.wmask, e.wmask, o.wdata, e.wdata, o.stall_bad, o.rdy_bad);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_byte_ext();
    test_sh_wait();
    test_sw_misaligned();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    test_random(200);
    @(negedge clk);
    quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Sequences one load/store at a time from the execute stage onto a valid/ready data-memory port.
- Holds the pipeline stalled while the access is outstanding and checks alignment before any bus traffic.
- Aligns and sign- or zero-extends load data, and raises misaligned and access-fault exceptions.
- Sits between the execute stage / LSU decode and the data-memory interconnect.

Parameters:
N, 64, datapath and address width in bits; must be a power of two, at least 32
TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is abandoned as an access fault; at least 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  execute stage presents a memory op
req_load  in  1  op is a load
req_store  in  1  op is a store
req_funct3  in  3  RV64 width/sign code
req_addr  in  N  effective byte address
req_storeData  in  N  store source, LSB-aligned
req_ready  out  1  op accepted this cycle
stall  out  1  hold pipeline
resp_valid  out  1  one-cycle completion pulse
resp_loadData  out  N  extended load result; 0 for stores
exc_valid  out  1  exception, qualified by resp_valid
exc_cause  out  2  0 load-misaligned, 1 store-misaligned, 2 load-fault, 3 store-fault
exc_addr  out  N  faulting address
mem_req_valid  out  1  bus request
mem_req_ready  in  1  bus accepts request
mem_we  out  1  write
mem_addr  out  N  byte address, unmodified
mem_wdata  out  N  lane-shifted store data
mem_wmask  out  N/8  byte enables
mem_rsp_valid  in  1  response or write acknowledge
mem_rsp_rdata  in  N  read data, full word
mem_rsp_err  in  1  bus error

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: state IDLE. Every output is 0. Timeout counter and all latched request fields are 0.
- Op decode: an op exists when req_valid && (req_load || req_store). If both are set, it is treated as a load.
- IDLE state:
  - On an op, req_ready=1 and stall=1 combinationally, and addr, funct3, type and data are latched.
  - Misaligned → RESP with exception, no bus traffic. Rules: halfword needs addr%2==0, word addr%4==0, double addr%8==0; bytes never misalign.
  - Invalid funct3 (store 1xx, load 111) → RESP with no exception, data 0, no bus traffic.
  - Otherwise → REQ, with the counter cleared.
- REQ state:
  - Outputs: mem_req_valid=1, mem_we = store, mem_addr = latched addr, stall=1.
  - Store mask: 1, 2, 4 or 8 consecutive ones shifted left by addr[2:0]. Store data: storeData << 8*addr[2:0]; SD is unshifted.
  - Loads drive mask 0 and wdata 0.
  - On mem_req_ready → WAIT. mem_rsp_valid is ignored in this state.
- WAIT state:
  - Outputs: stall=1, mem_req_valid=0.
  - On mem_rsp_valid, capture rdata and err → RESP.
- Timeout:
  - The counter increments each cycle in REQ and WAIT.
  - When it reaches TIMEOUT-1 with no handshake or response that cycle, go to RESP with an access fault and drop mem_req_valid.
  - A handshake or response in that same cycle takes priority over the timeout.
- RESP state:
  - resp_valid=1 for exactly one cycle, stall=0, req_ready=0, then → IDLE.
  - exc_valid=1 on misalignment, mem_rsp_err, or timeout. exc_cause is chosen by op type and cause. exc_addr = latched addr, otherwise 0.
  - On an exception, resp_loadData=0.
- Load extract: the latched rdata is shifted right by 8*addr[2:0], then:
  - LB/LH/LW: sign-extend from bit 7/15/31.
  - LBU/LHU/LWU: zero-extend.
  - LD: full 64 bits.
- Latency:
  - Misaligned or invalid op: accepted in cycle 0, resp_valid in cycle 1.
  - Aligned op with zero-wait bus: resp_valid in cycle 3.
- Late responses: mem_rsp_valid arriving in IDLE or RESP is dropped.
- Back-to-back: ops are not accepted in RESP. The next op is accepted in the IDLE cycle that follows.
- Reset mid-access: returns to IDLE immediately with outputs cleared; the outstanding bus transaction is abandoned.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU);
  - exc_cause_e enum;
  - lsu_state_e enum {IDLE, REQ, WAIT, RESP}.
- One combinational sub-module, lsu_load_align (rdata, offset, funct3 → extended data), instantiated once.

Test Plan:
- LW at 0x1004 with rdata 0x80000000_00000000, zero-wait bus → resp_valid in cycle 3, resp_loadData 0xFFFFFFFF_80000000, exc_valid 0.
- LBU at 0x1003 with rdata 0x00000000_F1000000 → resp_loadData 0x00000000_000000F1. LB on the same input → 0xFFFFFFFF_FFFFFFF1.
- SH at 0x2006 with data 0xABCD and mem_req_ready held low 3 cycles → mem_req_valid held 4 cycles, mem_wmask 0xC0, mem_wdata 0xABCD0000_00000000, stall high throughout, resp_valid after the ack.
- SW at 0x3002 → resp_valid in cycle 1, exc_cause 1, exc_addr 0x3002, mem_req_valid never asserted.
- LD at 0x4000 with mem_rsp_err=1 → exc_cause 2, resp_loadData 0. With TIMEOUT=4 and the bus silent → exc_cause 2 after 4 cycles in REQ.
- rst_n pulsed low while in WAIT → outputs 0 asynchronously. A later mem_rsp_valid in IDLE is ignored, and the next op completes normally.
